// File: rtl/lane_stripe_ctrl_1x2.sv
// lane_stripe_ctrl_1x2: stripes a framed byte stream across two lanes,
// padding odd-length packets on lane 1 so each packet starts on lane 0.
module lane_stripe_ctrl_1x2 #(
  parameter int                 DATA_W   = 8,
  parameter logic [DATA_W-1:0]  PAD_BYTE = 8'hF7,
  parameter int                 MAX_LEN  = 64
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              validIn,
  input  logic [DATA_W-1:0] In,
  input  logic              eopIn,
  output logic              readyIn,
  input  logic              ready0,
  input  logic              ready1,
  output logic              outValid0,
  output logic [DATA_W-1:0] data_out0,
  output logic              outValid1,
  output logic [DATA_W-1:0] data_out1,
  output logic [7:0]        pkt_cnt,
  output logic [6:0]        byte_cnt,
  output logic              err_overlen
);

  typedef enum logic [1:0] {
    L0  = 2'd0,
    L1  = 2'd1,
    PAD = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic w_acc;
  logic w_wr0;
  logic w_wr1;
  logic w_pad_go;
  logic w_done;
  logic [7:0] w_cnt_nxt;
  logic w_over;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_state <= L0;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      L0: begin
        if (w_acc) begin
          w_next = eopIn ? PAD : L1;
        end
      end
      L1: begin
        if (w_acc) begin
          w_next = L0;
        end
      end
      PAD: begin
        if (ready1) begin
          w_next = L0;
        end
      end
      default: w_next = L0;
    endcase
  end

  always_comb begin
    readyIn  = 1'b0;
    w_pad_go = 1'b0;
    unique case (r_state)
      L0:      readyIn  = reset_L & ready0;
      L1:      readyIn  = reset_L & ready1;
      PAD:     w_pad_go = reset_L & ready1;
      default: readyIn  = 1'b0;
    endcase
    w_acc  = validIn & readyIn;
    w_wr0  = w_acc & (r_state == L0);
    w_wr1  = w_acc & (r_state == L1);
    w_done = (w_wr1 & eopIn) | w_pad_go;
  end

  // byte count saturates at 127; overflow bit of the 8-bit sum marks it
  always_comb begin
    w_cnt_nxt = {1'b0, byte_cnt} + 8'd1;
    w_over    = w_acc & ~eopIn &
                (int'(w_cnt_nxt) >= MAX_LEN);
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      outValid0 <= 1'b0;
      data_out0 <= '0;
    end else begin
      outValid0 <= w_wr0;
      if (w_wr0) begin
        data_out0 <= In;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      outValid1 <= 1'b0;
      data_out1 <= '0;
    end else begin
      outValid1 <= w_wr1 | w_pad_go;
      if (w_pad_go) begin
        data_out1 <= PAD_BYTE;
      end else if (w_wr1) begin
        data_out1 <= In;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      pkt_cnt <= '0;
    end else if (w_done) begin
      pkt_cnt <= pkt_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      byte_cnt <= '0;
    end else if (w_done) begin
      byte_cnt <= '0;
    end else if (w_acc && !w_cnt_nxt[7]) begin
      byte_cnt <= w_cnt_nxt[6:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      err_overlen <= 1'b0;
    end else if (w_over) begin
      err_overlen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lane_stripe_ctrl_1x2.sv
// tb_lane_stripe_ctrl_1x2: random and directed stimulus checked
// against a packet-index reference model.
module tb_lane_stripe_ctrl_1x2;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       validIn;
  logic [7:0] In;
  logic       eopIn;
  logic       readyIn;
  logic       ready0;
  logic       ready1;
  logic       outValid0;
  logic [7:0] data_out0;
  logic       outValid1;
  logic [7:0] data_out1;
  logic [7:0] pkt_cnt;
  logic [6:0] byte_cnt;
  logic       err_overlen;

  always #5 clk = ~clk;

  lane_stripe_ctrl_1x2 dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .validIn    (validIn),
    .In         (In),
    .eopIn      (eopIn),
    .readyIn    (readyIn),
    .ready0     (ready0),
    .ready1     (ready1),
    .outValid0  (outValid0),
    .data_out0  (data_out0),
    .outValid1  (outValid1),
    .data_out1  (data_out1),
    .pkt_cnt    (pkt_cnt),
    .byte_cnt   (byte_cnt),
    .err_overlen(err_overlen)
  );

  int total = 0;
  int bad   = 0;

  // model: k = payload bytes taken in this packet, pad = pad owed
  int         m_k   = 0;
  bit         m_pad = 0;
  int         m_pkt = 0;
  bit         m_err = 0;
  bit         m_v0  = 0;
  bit         m_v1  = 0;
  logic [7:0] m_d0  = 0;
  logic [7:0] m_d1  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input bit rst, input bit v,
                     input logic [7:0] d, input bit e,
                     input bit r0, input bit r1,
                     output bit acc);
    bit rdy;
    @(negedge clk);
    reset_L = rst;
    validIn = v;
    In      = d;
    eopIn   = e;
    ready0  = r0;
    ready1  = r1;
    #1;
    rdy = rst && !m_pad && ((m_k % 2 == 0) ? r0 : r1);
    chk("readyIn", {31'd0, readyIn}, {31'd0, rdy});
    acc  = v && rdy;
    m_v0 = 0;
    m_v1 = 0;
    if (!rst) begin
      m_k = 0; m_pad = 0; m_pkt = 0; m_err = 0;
      m_d0 = 0; m_d1 = 0;
    end else if (m_pad) begin
      if (r1) begin
        m_v1  = 1;
        m_d1  = 8'hF7;
        m_pkt = (m_pkt + 1) % 256;
        m_k   = 0;
        m_pad = 0;
      end
    end else if (acc) begin
      if (m_k % 2 == 0) begin
        m_v0 = 1; m_d0 = d;
      end else begin
        m_v1 = 1; m_d1 = d;
      end
      m_k++;
      if (!e && m_k >= 64) m_err = 1;
      if (e) begin
        if (m_k % 2 == 1) m_pad = 1;
        else begin
          m_pkt = (m_pkt + 1) % 256;
          m_k   = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("outValid0", {31'd0, outValid0}, {31'd0, m_v0});
    chk("data_out0", {24'd0, data_out0}, {24'd0, m_d0});
    chk("outValid1", {31'd0, outValid1}, {31'd0, m_v1});
    chk("data_out1", {24'd0, data_out1}, {24'd0, m_d1});
    chk("pkt_cnt", {24'd0, pkt_cnt}, m_pkt);
    chk("byte_cnt", {25'd0, byte_cnt},
        (m_k > 127) ? 127 : m_k);
    chk("err_overlen", {31'd0, err_overlen}, {31'd0, m_err});
  endtask

  // hold one byte until taken; full=1 keeps valid and both lanes ready
  task automatic send(input logic [7:0] d, input bit e,
                      input bit full);
    bit acc;
    bit v, r0, r1;
    int n;
    acc = 0;
    for (n = 0; n < 200 && !acc; n++) begin
      v  = full || ($urandom_range(0, 3) != 0);
      r0 = full || ($urandom_range(0, 3) != 0);
      r1 = full || ($urandom_range(0, 3) != 0);
      cyc(1, v, d, e, r0, r1, acc);
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cyc(1, 0, 8'h00, 0, 1, 1, acc);
  endtask

  initial begin
    bit acc;
    int len;
    reset_L = 0; validIn = 0; In = 0; eopIn = 0;
    ready0 = 0; ready1 = 0;
    cyc(0, 1, 8'h55, 0, 1, 1, acc);
    cyc(0, 1, 8'h55, 0, 1, 1, acc);
    idle(2);

    send(8'h11, 0, 1); send(8'h22, 0, 1);
    send(8'h33, 0, 1); send(8'h44, 1, 1);
    idle(1);

    send(8'hA1, 0, 1); send(8'hA2, 0, 1);
    send(8'hA3, 1, 1);
    idle(3);

    // lane 1 stalls three cycles with the byte held
    send(8'h51, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 8'h52, 1, 1, 0, acc);
    send(8'h52, 1, 1);

    // odd packet ends while lane 1 is blocked
    send(8'h61, 1, 1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 8'h71, 0, 1, 0, acc);
    send(8'h71, 0, 1); send(8'h72, 1, 1);

    // reset in the middle of a 5-byte packet
    send(8'h81, 0, 1); send(8'h82, 0, 1);
    cyc(0, 1, 8'h83, 0, 1, 1, acc);
    send(8'h91, 0, 1); send(8'h92, 1, 1);

    // over-length packet, long enough to saturate byte_cnt
    for (int i = 0; i < 130; i++) send(8'(i), 0, 1);
    send(8'hEE, 1, 1);
    send(8'h01, 0, 1); send(8'h02, 1, 1);
    idle(2);
    cyc(0, 0, 8'h00, 0, 1, 1, acc);
    idle(1);

    for (int p = 0; p < 300; p++) begin
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++)
        send(8'($urandom), (i == len - 1), 0);
    end

    for (int i = 0; i < 1500; i++)
      cyc(($urandom_range(0, 39) != 0), 1'($urandom),
          8'($urandom), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 3) != 0), acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
